// File: rtl/redirect_ctrl.sv
// redirect_ctrl: EX-stage redirect sequencer with IFU handshake, flush drain and predictor training.
// Optional performance counters are built when REDIRECT_PERF_CNT_EN is defined.
module redirect_ctrl #(
  parameter int XLEN      = 64,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_is_br,
  input  logic             ex_is_trap,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic             bju_pc_b_j,
  input  logic [XLEN-1:0]  bju_dnpc,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_o,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_target,
  output logic [CNT_W-1:0] perf_br_cnt,
  output logic [CNT_W-1:0] perf_mis_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0]      state;
  logic [2:0]      cnt;
  logic            res, mis, train;
  logic [XLEN-1:0] tgt;
  always_comb begin
    res     = ex_valid & (ex_is_br | ex_is_trap) & (state == IDLE);
    mis     = ex_is_trap | (bju_pc_b_j != ex_pred_taken) |
              (bju_pc_b_j & ex_pred_taken & (bju_dnpc != ex_pred_target));
    tgt     = bju_pc_b_j ? bju_dnpc : ex_pc + XLEN'(4);
    train   = res & ex_is_br & ~ex_is_trap;
    flush_o = (state != IDLE) | (res & mis);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
    end else begin
      upd_valid <= train;
      if (train) begin
        upd_pc     <= ex_pc;
        upd_taken  <= bju_pc_b_j;
        upd_target <= bju_dnpc;
      end
      if (state == IDLE) begin
        if (res & mis) begin
          state          <= PEND;
          redirect_valid <= 1'b1;
          redirect_pc    <= tgt;
        end
      end else if (state == PEND) begin
        if (redirect_ready) begin
          state          <= DRAIN;
          redirect_valid <= 1'b0;
          cnt            <= 3'(DRAIN_CYC);
        end
      end else if (state == DRAIN) begin
        if (cnt == 3'd1) state <= IDLE;
        else cnt <= cnt - 3'd1;
      end else begin
        state <= IDLE;
      end
    end
  end
`ifdef REDIRECT_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else begin
      perf_br_cnt  <= perf_br_cnt + CNT_W'(train);
      perf_mis_cnt <= perf_mis_cnt + CNT_W'(res & mis & ~ex_is_trap);
    end
  end
`else
  assign perf_br_cnt  = '0;
  assign perf_mis_cnt = '0;
`endif
endmodule

// File: tb/tb_redirect_ctrl.sv
// tb_redirect_ctrl: table-driven directed checks plus hand sequences for backpressure, reset and counters.
module tb_redirect_ctrl;
  localparam int XLEN = 64;
  localparam int DR   = 2;
  localparam int CW   = 32;
`ifdef REDIRECT_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_is_br, ex_is_trap, ex_pred_taken, bju_pc_b_j, redirect_ready;
  logic [XLEN-1:0] ex_pc, ex_pred_target, bju_dnpc;
  logic            redirect_valid, flush_o, upd_valid, upd_taken;
  logic [XLEN-1:0] redirect_pc, upd_pc, upd_target;
  logic [CW-1:0]   perf_br_cnt, perf_mis_cnt;
  redirect_ctrl #(.XLEN(XLEN), .DRAIN_CYC(DR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_br(ex_is_br),
    .ex_is_trap(ex_is_trap), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .bju_pc_b_j(bju_pc_b_j), .bju_dnpc(bju_dnpc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .flush_o(flush_o),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v, br, trap, pt, pbj;
    logic [63:0] pc, ptgt, dnpc;
    logic e_flush, e_rv, e_upd, e_taken;
    logic [63:0] e_rpc;
  } vec_t;
  vec_t vt [10];
  int n_run = 0;
  int n_fail = 0;
  int m_br = 0;
  int m_mis = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic v, logic br, logic trap, logic pt, logic [63:0] pc,
                              logic [63:0] ptgt, logic pbj, logic [63:0] dnpc, logic e_flush,
                              logic e_rv, logic [63:0] e_rpc, logic e_upd, logic e_taken);
    vec_t t;
    t.v = v; t.br = br; t.trap = trap; t.pt = pt; t.pc = pc; t.ptgt = ptgt; t.pbj = pbj;
    t.dnpc = dnpc; t.e_flush = e_flush; t.e_rv = e_rv; t.e_rpc = e_rpc; t.e_upd = e_upd;
    t.e_taken = e_taken;
    return t;
  endfunction
  task automatic drive(input logic v, input logic br, input logic trap, input logic pt,
                       input logic [63:0] pc, input logic [63:0] ptgt, input logic pbj,
                       input logic [63:0] dnpc);
    ex_valid = v; ex_is_br = br; ex_is_trap = trap; ex_pred_taken = pt; ex_pc = pc;
    ex_pred_target = ptgt; bju_pc_b_j = pbj; bju_dnpc = dnpc;
  endtask
  task automatic idle_in;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0);
  endtask
  task automatic check_drain(input string tag);
    for (int d = 0; d < DR; d++) begin
      chk($sformatf("%s drain%0d flush", tag, d), flush_o, 1'b1);
      chk($sformatf("%s drain%0d rv", tag, d), redirect_valid, 1'b0);
      tick;
    end
    redirect_ready = 1'b0;
    idle_in;
    #1;
    chk($sformatf("%s idle flush", tag), flush_o, 1'b0);
    chk($sformatf("%s idle rv", tag), redirect_valid, 1'b0);
  endtask
  initial begin
    //       v  br tr pt pc                      ptgt                    pbj dnpc                   fl rv rpc                     upd tk
    vt[0] = mk(1, 1, 0, 1, 64'h8000_0000,          64'h8000_0040,          1, 64'h8000_0040,          0, 0, 64'h0,                  1, 1);
    vt[1] = mk(1, 1, 0, 1, 64'h8000_0100,          64'h8000_0200,          0, 64'h8000_0200,          1, 1, 64'h8000_0104,          1, 0);
    vt[2] = mk(1, 0, 1, 0, 64'h8000_0300,          64'h0,                  1, 64'h8000_1000,          1, 1, 64'h8000_1000,          0, 0);
    vt[3] = mk(1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10,                 0, 64'h10,                 1, 1, 64'h0,                  1, 0);
    vt[4] = mk(1, 1, 0, 1, 64'h1000,               64'h2000,               1, 64'h3000,               1, 1, 64'h3000,               1, 1);
    vt[5] = mk(1, 1, 0, 0, 64'h4000,               64'h0,                  1, 64'h5000,               1, 1, 64'h5000,               1, 1);
    vt[6] = mk(1, 1, 0, 0, 64'h6000,               64'h9999,               0, 64'h9999,               0, 0, 64'h0,                  1, 0);
    vt[7] = mk(1, 1, 1, 1, 64'h7000,               64'h8000,               1, 64'h8000,               1, 1, 64'h8000,               0, 0);
    vt[8] = mk(0, 1, 0, 1, 64'h7100,               64'h8000,               0, 64'h8000,               0, 0, 64'h0,                  0, 0);
    vt[9] = mk(1, 0, 0, 1, 64'h7200,               64'h8000,               0, 64'h8000,               0, 0, 64'h0,                  0, 0);
    rst_n = 1'b0;
    redirect_ready = 1'b0;
    idle_in;
    #12;
    chk("reset rv", redirect_valid, 1'b0);
    chk("reset rpc", redirect_pc, 64'h0);
    chk("reset flush", flush_o, 1'b0);
    chk("reset upd", upd_valid, 1'b0);
    chk("reset br_cnt", 64'(perf_br_cnt), 64'h0);
    chk("reset mis_cnt", 64'(perf_mis_cnt), 64'h0);
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v, vt[i].br, vt[i].trap, vt[i].pt, vt[i].pc, vt[i].ptgt, vt[i].pbj, vt[i].dnpc);
      #1;
      chk($sformatf("v%0d flush", i), flush_o, vt[i].e_flush);
      tick;
      chk($sformatf("v%0d rv", i), redirect_valid, vt[i].e_rv);
      if (vt[i].e_rv) chk($sformatf("v%0d rpc", i), redirect_pc, vt[i].e_rpc);
      chk($sformatf("v%0d upd_valid", i), upd_valid, vt[i].e_upd);
      if (vt[i].e_upd) begin
        chk($sformatf("v%0d upd_pc", i), upd_pc, vt[i].pc);
        chk($sformatf("v%0d upd_taken", i), upd_taken, vt[i].e_taken);
        chk($sformatf("v%0d upd_target", i), upd_target, vt[i].dnpc);
      end
      m_br += int'(vt[i].e_upd);
      m_mis += int'(vt[i].e_upd & vt[i].e_rv);
      idle_in;
      redirect_ready = vt[i].e_rv;
      tick;
      chk($sformatf("v%0d upd pulse end", i), upd_valid, 1'b0);
      if (vt[i].e_rv) check_drain($sformatf("v%0d", i));
      else chk($sformatf("v%0d no flush", i), flush_o, 1'b0);
    end
    chk("table br_cnt", 64'(perf_br_cnt), PERF ? 64'(m_br) : 64'h0);
    chk("table mis_cnt", 64'(perf_mis_cnt), PERF ? 64'(m_mis) : 64'h0);
    // backpressure: 5 stalled PEND cycles with live branches that must be ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0500, 64'h0, 1'b1, 64'h8000_0600);
    tick;
    chk("bp upd first", upd_valid, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0700, 64'h8000_0800, 1'b0, 64'h8000_0900);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d rv", k), redirect_valid, 1'b1);
      chk($sformatf("bp%0d rpc", k), redirect_pc, 64'h8000_0600);
      chk($sformatf("bp%0d flush", k), flush_o, 1'b1);
      if (k > 0) chk($sformatf("bp%0d upd", k), upd_valid, 1'b0);
      tick;
    end
    chk("bp hold rv", redirect_valid, 1'b1);
    redirect_ready = 1'b1;
    tick;
    chk("bp drain upd", upd_valid, 1'b0);
    check_drain("bp");
    chk("bp post upd", upd_valid, 1'b0);
    chk("bp br_cnt", 64'(perf_br_cnt), PERF ? 64'(m_br + 1) : 64'h0);
    chk("bp mis_cnt", 64'(perf_mis_cnt), PERF ? 64'(m_mis + 1) : 64'h0);
    // reset while a redirect is pending
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h9000, 64'h9100, 1'b0, 64'h9100);
    tick;
    idle_in;
    chk("rst pend rv before", redirect_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst pend rv", redirect_valid, 1'b0);
    chk("rst pend flush", flush_o, 1'b0);
    chk("rst pend br_cnt", 64'(perf_br_cnt), 64'h0);
    chk("rst pend mis_cnt", 64'(perf_mis_cnt), 64'h0);
    tick;
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    tick;
    tick;
    chk("rst post rv", redirect_valid, 1'b0);
    chk("rst post flush", flush_o, 1'b0);
    redirect_ready = 1'b0;
    // three branches, one mispredicted
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hA000, 64'hA040, 1'b1, 64'hA040);
    tick;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hA100, 64'h0, 1'b0, 64'hB000);
    tick;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'hA200, 64'h0, 1'b1, 64'hC000);
    tick;
    idle_in;
    chk("cnt rv", redirect_valid, 1'b1);
    chk("cnt rpc", redirect_pc, 64'hC000);
    redirect_ready = 1'b1;
    tick;
    check_drain("cnt");
    chk("cnt br_cnt", 64'(perf_br_cnt), PERF ? 64'd3 : 64'h0);
    chk("cnt mis_cnt", 64'(perf_mis_cnt), PERF ? 64'd1 : 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
